// File: rtl/divide_tokens.sv
// Token-rate divider: one output token per RATIO input tokens, with a saturating
// queue of pending output tokens drained by a valid/ready handshake.
module divide_tokens #(
  parameter int RATIO = 2,
  parameter int CNT_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     a,
  input  logic                     b_ready,
  output logic                     b,
  output logic [$clog2(RATIO)-1:0] remainder,
  output logic [CNT_W-1:0]         pending,
  output logic                     overflow
);

  localparam int REM_W = $clog2(RATIO);
  localparam logic [REM_W-1:0] REM_LAST = REM_W'(RATIO - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             gen;
  logic             pop;
  logic             ovf_set;
  logic [CNT_W-1:0] pending_nxt;

  assign gen = a && (remainder == REM_LAST);
  // b mirrors pending != 0, so a pop can never hit an empty queue
  assign pop = b && b_ready;

  always_comb begin
    pending_nxt = pending;
    ovf_set     = 1'b0;
    if (gen && !pop) begin
      if (pending == CNT_MAX) ovf_set = 1'b1;
      else                    pending_nxt = pending + CNT_W'(1);
    end else if (!gen && pop) begin
      pending_nxt = pending - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      remainder <= '0;
      pending   <= '0;
      b         <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (a) remainder <= gen ? '0 : remainder + REM_W'(1);
      pending <= pending_nxt;
      b       <= (pending_nxt != '0);
      if (ovf_set) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divide_tokens.sv
// Directed bench for divide_tokens: RATIO=2 instance for most scenarios and a
// RATIO=3 instance for the group-of-three pulse pattern.
module tb_divide_tokens;

  logic       clk;
  logic       rst_n;
  logic       a2, br2, b2, ovf2;
  logic [0:0] rem2;
  logic [3:0] pend2;
  logic       a3, br3, b3, ovf3;
  logic [1:0] rem3;
  logic [3:0] pend3;

  int total = 0;
  int bad   = 0;
  int hs2   = 0;
  int hs3   = 0;
  int n_a   = 0;

  divide_tokens #(.RATIO(2), .CNT_W(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a2), .b_ready(br2),
    .b(b2), .remainder(rem2), .pending(pend2), .overflow(ovf2));

  divide_tokens #(.RATIO(3), .CNT_W(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .a(a3), .b_ready(br3),
    .b(b3), .remainder(rem3), .pending(pend3), .overflow(ovf3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // count handshakes about to happen at the coming edge, then advance one cycle
  task automatic step();
    if (b2 && br2) hs2++;
    if (b3 && br3) hs3++;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    a2 = 1'b0; br2 = 1'b0; a3 = 1'b0; br3 = 1'b0;
    #12;
    chk("rst_b", b2, 0);
    chk("rst_rem", rem2, 0);
    chk("rst_pend", pend2, 0);
    chk("rst_ovf", ovf2, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // RATIO=3: remainder 1,2,0 and a 1-cycle b pulse every third token
    br3 = 1'b1;
    a3  = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      step();
      chk($sformatf("r3_rem_%0d", i), rem3, i % 3);
      chk($sformatf("r3_b_%0d", i), b3, (i % 3 == 0) ? 1 : 0);
    end
    a3 = 1'b0;
    step();
    chk("r3_b_end", b3, 0);
    chk("r3_hs", hs3, 3);

    // random stream, RATIO=2
    br2 = 1'b1;
    hs2 = 0;
    n_a = 0;
    for (int i = 0; i < 100; i++) begin
      a2 = ($urandom_range(0, 99) < 30);
      if (a2) n_a++;
      step();
    end
    a2 = 1'b0;
    for (int i = 0; i < 200; i++) step();
    chk("rand_hs", hs2, n_a / 2);
    chk("rand_rem", rem2, n_a % 2);
    chk("rand_pend", pend2, 0);
    chk("rand_ovf", ovf2, 0);

    // backpressure: six tokens queue three outputs whatever the starting phase
    br2 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a2 = 1'b1; step();
      a2 = 1'b0; step();
    end
    chk("bp_pend", pend2, 3);
    chk("bp_b", b2, 1);
    step();
    chk("bp_b_hold", b2, 1);
    chk("bp_pend_hold", pend2, 3);
    br2 = 1'b1;
    hs2 = 0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_drain_b_%0d", i), b2, 1);
      step();
    end
    chk("bp_hs", hs2, 3);
    chk("bp_pend_0", pend2, 0);
    chk("bp_b_0", b2, 0);

    // simultaneous gen and pop at pending=2
    pulse_reset();
    br2 = 1'b0;
    a2  = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("gp_pre_pend", pend2, 2);
    chk("gp_pre_rem", rem2, 1);
    br2 = 1'b1;
    step();
    chk("gp_pend", pend2, 2);
    chk("gp_rem", rem2, 0);
    // and again with the queue full
    br2 = 1'b0;
    for (int i = 0; i < 27; i++) step();
    chk("gpf_pre_pend", pend2, 15);
    chk("gpf_pre_rem", rem2, 1);
    chk("gpf_pre_ovf", ovf2, 0);
    br2 = 1'b1;
    step();
    chk("gpf_pend", pend2, 15);
    chk("gpf_rem", rem2, 0);
    chk("gpf_ovf", ovf2, 0);

    // overflow: 1000 tokens into a blocked queue
    a2 = 1'b0;
    pulse_reset();
    br2 = 1'b0;
    a2  = 1'b1;
    for (int k = 1; k <= 1000; k++) begin
      step();
      if (k == 29) chk("ov_pend_29", pend2, 14);
      if (k == 30) chk("ov_pend_30", pend2, 15);
      if (k == 31) chk("ov_ovf_31", ovf2, 0);
      if (k == 32) chk("ov_ovf_32", ovf2, 1);
    end
    chk("ov_pend_end", pend2, 15);
    chk("ov_ovf_end", ovf2, 1);
    a2  = 1'b0;
    br2 = 1'b1;
    hs2 = 0;
    for (int i = 0; i < 20; i++) step();
    chk("ov_drain_hs", hs2, 15);
    chk("ov_drain_pend", pend2, 0);
    chk("ov_drain_ovf", ovf2, 1);

    // asynchronous reset mid-stream
    br2 = 1'b0;
    a2  = 1'b1;
    for (int i = 0; i < 11; i++) step();
    a2 = 1'b0;
    chk("mr_pre_pend", pend2, 5);
    chk("mr_pre_rem", rem2, 1);
    chk("mr_pre_ovf", ovf2, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_b", b2, 0);
    chk("mr_rem", rem2, 0);
    chk("mr_pend", pend2, 0);
    chk("mr_ovf", ovf2, 0);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    br2 = 1'b1;
    hs2 = 0;
    a2  = 1'b1;
    step();
    step();
    a2 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("mr_hs", hs2, 1);
    chk("mr_post_pend", pend2, 0);
    chk("mr_post_rem", rem2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
